match_ctrl: RTL

//  Match sequencer for the two-player pong game. It sequences the ball datapath
//   (load at centre, serve, rally) and feeds the scoreboard single-cycle point

---
 rtl/pong_defs.sv | 20 ++
 rtl/match_ctrl_tick_timer.sv | 44 ++++
 rtl/match_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pong_defs.sv
// Shared definitions for the pong match logic: state encodings, player ids
// and the game length.
package pong_defs;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned WIN_POINTS = 7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // Player ids as stored in the server flop.
    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

endpackage

// File: rtl/match_ctrl_tick_timer.sv
// Frame-tick timer shared by SERVE and PAUSE.
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   clr         hold count at zero (owner state not active)
//   tick        qualified frame strobe, counts one per pulse
//   limit       terminal count (duration - 1)
//   expire_c    combinational: tick arriving while count == limit
module match_ctrl_tick_timer #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          tick,
    input  logic [CW-1:0] limit,
    output logic          expire_c
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry always coincides with leaving the owning state, so the count
    // restarts from zero there; PAUSE hands straight over to SERVE.
    always_comb begin
        cnt_d    = cnt_q;
        expire_c = tick && (cnt_q == limit);
        if (clr) begin
            cnt_d = '0;
        end else if (expire_c) begin
            cnt_d = '0;
        end else if (tick && (cnt_q < limit)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/match_ctrl.sv
// Match sequencer for two-player pong: drives the ball datapath through
// serve / rally / pause and emits single-cycle point and clear pulses to the
// scoreboard, whose playing flag decides when the match is over.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   tick              frame strobe (1 clk)
//   start             start button level; rising edge starts a match
//   serve1, serve2    serve button levels
//   miss1, miss2      ball passed player 1 / player 2 paddle (1 clk)
//   playing, winner   scoreboard status
//   point1, point2    add-point pulses
//   score_clr         scoreboard clear pulse
//   ball_load         hold ball at centre
//   ball_run          ball in motion
//   serve_dir         1 = launch toward player 2
//   game_over         match finished
//   state_dbg         current state encoding
module match_ctrl
    import pong_defs::*;
#(
    parameter int unsigned PAUSE_TICKS = 30,
    parameter int unsigned SERVE_TICKS = 120,
    parameter int unsigned CW          = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               serve1,
    input  logic               serve2,
    input  logic               miss1,
    input  logic               miss2,
    input  logic               playing,
    input  logic               winner,
    output logic               point1,
    output logic               point2,
    output logic               score_clr,
    output logic               ball_load,
    output logic               ball_run,
    output logic               serve_dir,
    output logic               game_over,
    output logic [STATE_W-1:0] state_dbg
);

    state_e state_q, state_d;
    logic   server_q, server_d;
    logic   start_q;
    logic   point1_q, point1_d;
    logic   point2_q, point2_d;
    logic   score_clr_q, score_clr_d;
    logic   ball_load_q, ball_load_d;
    logic   ball_run_q, ball_run_d;
    logic   serve_dir_q, serve_dir_d;
    logic   game_over_q, game_over_d;

    logic          start_rise_c;
    logic          serve_btn_c;
    logic          timing_c;
    logic          expire_c;
    logic [CW-1:0] limit_c;
    logic          winner_unused_c;

    // The winner flag is for the display path; sequencing only needs playing.
    assign winner_unused_c = winner;

    assign start_rise_c = start && !start_q;
    assign serve_btn_c  = (server_q == P1) ? serve1 : serve2;
    assign timing_c     = (state_q == ST_SERVE) || (state_q == ST_PAUSE);
    assign limit_c      = (state_q == ST_SERVE) ? CW'(SERVE_TICKS - 1)
                                                : CW'(PAUSE_TICKS - 1);

    match_ctrl_tick_timer #(
        .CW(CW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (!timing_c),
        .tick     (tick && timing_c),
        .limit    (limit_c),
        .expire_c (expire_c)
    );

    // Next state, server and registered-output inputs.
    always_comb begin
        state_d     = state_q;
        server_d    = server_q;
        point1_d    = 1'b0;
        point2_d    = 1'b0;
        score_clr_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise_c) begin
                    state_d     = ST_SERVE;
                    score_clr_d = 1'b1;
                    server_d    = P1;
                end
            end
            ST_SERVE: begin
                if (serve_btn_c || expire_c) begin
                    state_d = ST_RALLY;
                end
            end
            ST_RALLY: begin
                // A simultaneous double miss is a replay with no score change.
                if (miss1 && miss2) begin
                    state_d = ST_PAUSE;
                end else if (miss1) begin
                    state_d  = ST_PAUSE;
                    point2_d = 1'b1;
                    server_d = P1;
                end else if (miss2) begin
                    state_d  = ST_PAUSE;
                    point1_d = 1'b1;
                    server_d = P2;
                end
            end
            ST_PAUSE: begin
                if (expire_c) begin
                    state_d = playing ? ST_SERVE : ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ball_load_d = (state_d != ST_RALLY);
        ball_run_d  = (state_d == ST_RALLY);
        game_over_d = (state_d == ST_OVER);
        // Direction is meaningless while idle; park it at its reset value.
        serve_dir_d = (state_d == ST_IDLE) ? 1'b0 : (server_d == P1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            server_q    <= P1;
            start_q     <= 1'b0;
            point1_q    <= 1'b0;
            point2_q    <= 1'b0;
            score_clr_q <= 1'b0;
            ball_load_q <= 1'b1;
            ball_run_q  <= 1'b0;
            serve_dir_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            server_q    <= server_d;
            start_q     <= start;
            point1_q    <= point1_d;
            point2_q    <= point2_d;
            score_clr_q <= score_clr_d;
            ball_load_q <= ball_load_d;
            ball_run_q  <= ball_run_d;
            serve_dir_q <= serve_dir_d;
            game_over_q <= game_over_d;
        end
    end

    assign point1    = point1_q;
    assign point2    = point2_q;
    assign score_clr = score_clr_q;
    assign ball_load = ball_load_q;
    assign ball_run  = ball_run_q;
    assign serve_dir = serve_dir_q;
    assign game_over = game_over_q;
    assign state_dbg = state_q;

endmodule
